cu_sequencer: RTL and testbench

- Fetch/decode/execute controller for the 4-bit computational unit.
- Holds the 8-bit program counter and fetches 8-bit instructions from a program ROM with ROM_LAT cycles of latency.
- Decodes each instruction into that unit's source select, register enables, x/y/i selects and ALU nibble for exactly one execute cycle.
- Resolves unconditional jumps and jump-if-not-zero branches, the latter using the unit's zero flag.

---
 rtl/cu_seq_pkg.sv | 76 +++++++
 rtl/cu_instr_decoder.sv | 55 +++++
 rtl/cu_sequencer.sv | 124 ++++++++++++
 tb/tb_cu_sequencer.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cu_seq_pkg.sv
// Shared types and encodings for the cu_sequencer fetch/decode/execute controller.
// Used by cu_instr_decoder and cu_sequencer.
package cu_seq_pkg;

    typedef enum logic [2:0] {
        ST_RST   = 3'd0,
        ST_FETCH = 3'd1,
        ST_WAIT  = 3'd2,
        ST_EXEC  = 3'd3,
        ST_IDLE  = 3'd4,
        ST_HALT  = 3'd5
    } cu_state_e;

    typedef enum logic [2:0] {
        OPC_LDI,
        OPC_MOV,
        OPC_ALU,
        OPC_JMP,
        OPC_JNZ
    } opc_e;

    typedef enum logic [1:0] {
        JK_NONE,
        JK_JMP,
        JK_JNZ
    } jump_kind_e;

    // Destination codes carried in the instruction word.
    localparam logic [2:0] DST_X0   = 3'd0;
    localparam logic [2:0] DST_X1   = 3'd1;
    localparam logic [2:0] DST_Y0   = 3'd2;
    localparam logic [2:0] DST_Y1   = 3'd3;
    localparam logic [2:0] DST_OREG = 3'd4;
    localparam logic [2:0] DST_M    = 3'd5;
    localparam logic [2:0] DST_I    = 3'd6;
    localparam logic [2:0] DST_DM   = 3'd7;

    localparam logic [3:0] SRC_IMM  = 4'd8;
    localparam logic [3:0] SRC_PINS = 4'd9;

    localparam int EN_X0   = 0;
    localparam int EN_X1   = 1;
    localparam int EN_Y0   = 2;
    localparam int EN_Y1   = 3;
    localparam int EN_R    = 4;
    localparam int EN_M    = 5;
    localparam int EN_I    = 6;
    localparam int EN_DM   = 7;
    localparam int EN_OREG = 8;

    function automatic opc_e opc_class(input logic [7:0] ir);
        if (!ir[7])      return OPC_LDI;
        else if (!ir[6]) return OPC_MOV;
        else if (!ir[5]) return OPC_ALU;
        else if (!ir[4]) return OPC_JMP;
        else             return OPC_JNZ;
    endfunction

    // Destination code to write-enable bit; o_reg and dm sit above r in the enable vector.
    function automatic logic [8:0] dst_onehot(input logic [2:0] dst);
        logic [8:0] en;
        en = '0;
        case (dst)
            DST_X0:   en[EN_X0]   = 1'b1;
            DST_X1:   en[EN_X1]   = 1'b1;
            DST_Y0:   en[EN_Y0]   = 1'b1;
            DST_Y1:   en[EN_Y1]   = 1'b1;
            DST_OREG: en[EN_OREG] = 1'b1;
            DST_M:    en[EN_M]    = 1'b1;
            DST_I:    en[EN_I]    = 1'b1;
            DST_DM:   en[EN_DM]   = 1'b1;
        endcase
        return en;
    endfunction

endpackage

// File: rtl/cu_instr_decoder.sv
// Combinational instruction decoder: ir -> data-bus source, raw write enables,
// operand selects and jump kind. Enables are gated with EXEC by the sequencer.
module cu_instr_decoder
    import cu_seq_pkg::*;
(
    input  logic [7:0]  ir,
    output logic [3:0]  source_sel,
    output logic [8:0]  reg_en_raw,
    output logic        x_sel,
    output logic        y_sel,
    output logic        i_sel,
    output logic [3:0]  nibble_ir,
    output jump_kind_e  jump_kind
);

    logic [2:0] w_mov_dst;
    logic [2:0] w_mov_src;

    assign w_mov_dst = ir[5:3];
    assign w_mov_src = ir[2:0];
    assign nibble_ir = ir[3:0];

    always_comb begin
        source_sel = '0;
        reg_en_raw = '0;
        x_sel      = 1'b0;
        y_sel      = 1'b0;
        i_sel      = 1'b0;
        jump_kind  = JK_NONE;
        unique case (opc_class(ir))
            OPC_LDI: begin
                source_sel = SRC_IMM;
                reg_en_raw = dst_onehot(ir[6:4]);
            end
            OPC_MOV: begin
                reg_en_raw = dst_onehot(w_mov_dst);
                source_sel = {1'b0, w_mov_src};
                // A self-move has no use as a copy, so it is repurposed.
                if (w_mov_src == w_mov_dst) begin
                    if (w_mov_dst == DST_I) i_sel = 1'b1;
                    else                    source_sel = SRC_PINS;
                end
            end
            OPC_ALU: begin
                reg_en_raw[EN_R] = 1'b1;
                x_sel            = ir[4];
                y_sel            = ir[3];
            end
            OPC_JMP: jump_kind = JK_JMP;
            OPC_JNZ: jump_kind = JK_JNZ;
            default: ;
        endcase
    end

endmodule

// File: rtl/cu_sequencer.sv
// Fetch/decode/execute controller for the 4-bit computational unit.
// Optional single-step mode: define CU_SEQ_SINGLE_STEP_EN.
module cu_sequencer
    import cu_seq_pkg::*;
#(
    parameter int ROM_LAT = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic [7:0]  pm_addr,
    input  logic [7:0]  pm_data,
    input  logic        r_eq_0,
    output logic        cu_sync_reset,
    output logic [3:0]  nibble_ir,
    output logic [3:0]  source_sel,
    output logic [8:0]  reg_en,
    output logic        x_sel,
    output logic        y_sel,
    output logic        i_sel,
    output logic [7:0]  pc,
    output logic [7:0]  ir,
    output logic        halted,
`ifdef CU_SEQ_SINGLE_STEP_EN
    input  logic        step_req,
    output logic        step_idle,
`endif
    output logic [2:0]  dbg_state
);

`ifdef CU_SEQ_SINGLE_STEP_EN
    localparam cu_state_e ST_NEXT_INSTR = ST_IDLE;
`else
    localparam cu_state_e ST_NEXT_INSTR = ST_FETCH;
`endif

    cu_state_e  r_state;
    cu_state_e  w_next_state;
    logic [7:0] r_pc;
    logic [7:0] r_ir;
    logic [1:0] r_wait_cnt;
    logic       r_halted;

    logic [8:0] w_reg_en_raw;
    jump_kind_e w_jump_kind;
    logic       w_jump_taken;
    logic [7:0] w_jump_target;
    logic       w_halt_hit;

    cu_instr_decoder u_dec (
        .ir         (r_ir),
        .source_sel (source_sel),
        .reg_en_raw (w_reg_en_raw),
        .x_sel      (x_sel),
        .y_sel      (y_sel),
        .i_sel      (i_sel),
        .nibble_ir  (nibble_ir),
        .jump_kind  (w_jump_kind)
    );

    assign w_jump_target = {r_pc[7:4], r_ir[3:0]};
    assign w_jump_taken  = (w_jump_kind == JK_JMP) || ((w_jump_kind == JK_JNZ) && !r_eq_0);
    assign w_halt_hit    = w_jump_taken && (w_jump_target == r_pc);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= ST_RST;
        else          r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_RST:   w_next_state = ST_NEXT_INSTR;
            ST_IDLE: begin
`ifdef CU_SEQ_SINGLE_STEP_EN
                if (step_req) w_next_state = ST_FETCH;
`else
                w_next_state = ST_FETCH;
`endif
            end
            ST_FETCH: w_next_state = (ROM_LAT == 1) ? ST_EXEC : ST_WAIT;
            ST_WAIT:  if (r_wait_cnt == 2'd1) w_next_state = ST_EXEC;
            ST_EXEC:  w_next_state = w_halt_hit ? ST_HALT : ST_NEXT_INSTR;
            ST_HALT:  w_next_state = ST_HALT;
            default:  w_next_state = ST_RST;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pc       <= '0;
            r_ir       <= '0;
            r_wait_cnt <= '0;
            r_halted   <= 1'b0;
        end else begin
            case (r_state)
                ST_FETCH: begin
                    if (ROM_LAT == 1) r_ir       <= pm_data;
                    else              r_wait_cnt <= 2'(ROM_LAT - 1);
                end
                ST_WAIT: begin
                    r_wait_cnt <= r_wait_cnt - 2'd1;
                    if (r_wait_cnt == 2'd1) r_ir <= pm_data;
                end
                ST_EXEC: begin
                    r_pc <= w_jump_taken ? w_jump_target : r_pc + 8'd1;
                    if (w_halt_hit) r_halted <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign pm_addr       = r_pc;
    assign pc            = r_pc;
    assign ir            = r_ir;
    assign halted        = r_halted;
    assign cu_sync_reset = (r_state == ST_RST);
    assign reg_en        = (r_state == ST_EXEC) ? w_reg_en_raw : 9'd0;
    assign dbg_state     = r_state;
`ifdef CU_SEQ_SINGLE_STEP_EN
    assign step_idle     = (r_state == ST_IDLE);
`endif

endmodule

// File: tb/tb_cu_sequencer.sv
// Self-checking bench for cu_sequencer (ROM_LAT=2); exercises single-step mode
// too when CU_SEQ_SINGLE_STEP_EN is defined.
module tb_cu_sequencer;
    import cu_seq_pkg::*;

    localparam int ROM_LAT = 2;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] pm_addr;
    logic [7:0] pm_data = 8'h00;
    logic       r_eq_0;
    logic       cu_sync_reset;
    logic [3:0] nibble_ir;
    logic [3:0] source_sel;
    logic [8:0] reg_en;
    logic       x_sel, y_sel, i_sel;
    logic [7:0] pc, ir;
    logic       halted;
    logic [2:0] dbg_state;
`ifdef CU_SEQ_SINGLE_STEP_EN
    logic       step_req;
    logic       step_idle;
    logic       auto_step = 1'b1;
    logic       step_man = 1'b0;
    assign step_req = auto_step ? step_idle : step_man;
`endif

    cu_sequencer #(.ROM_LAT(ROM_LAT)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .pm_addr       (pm_addr),
        .pm_data       (pm_data),
        .r_eq_0        (r_eq_0),
        .cu_sync_reset (cu_sync_reset),
        .nibble_ir     (nibble_ir),
        .source_sel    (source_sel),
        .reg_en        (reg_en),
        .x_sel         (x_sel),
        .y_sel         (y_sel),
        .i_sel         (i_sel),
        .pc            (pc),
        .ir            (ir),
        .halted        (halted),
`ifdef CU_SEQ_SINGLE_STEP_EN
        .step_req      (step_req),
        .step_idle     (step_idle),
`endif
        .dbg_state     (dbg_state)
    );

    always #5 clk = ~clk;

    // Program ROM model: the address seen at one edge has its data visible
    // after the next edge, so data is usable ROM_LAT(=2) edges after presentation.
    logic [7:0] rom [256];
    logic       zflag [256];
    always @(posedge clk) pm_data <= rom[pm_addr];
    assign r_eq_0 = zflag[pm_addr];

    typedef struct packed {
        logic [7:0] pc;
        logic [7:0] ir;
        logic [3:0] ss;
        logic [2:0] mask;   // [0] source_sel, [1] x/y/nibble, [2] i_sel
        logic [8:0] en;
        logic       x;
        logic       y;
        logic       isel;
        logic [3:0] nib;
        logic [7:0] nxt;
    } exp_t;

    exp_t       exp_q[$];
    int         n_cmp = 0;
    int         n_err = 0;
    bit         mon_en = 1'b0;
    bit         pend_next = 1'b0;
    logic [7:0] exp_next;

    function automatic logic [8:0] exp_dst_en(input logic [2:0] d);
        case (d)
            3'd0: return 9'h001;
            3'd1: return 9'h002;
            3'd2: return 9'h004;
            3'd3: return 9'h008;
            3'd4: return 9'h100;
            3'd5: return 9'h020;
            3'd6: return 9'h040;
            default: return 9'h080;
        endcase
    endfunction

    task automatic push_exp(input logic [7:0] pc_v, input logic [7:0] ir_v, input logic [3:0] ss,
                            input logic [2:0] mask, input logic [8:0] en, input logic x,
                            input logic y, input logic isel, input logic [3:0] nib,
                            input logic [7:0] nxt);
        exp_t e;
        e.pc = pc_v; e.ir = ir_v; e.ss = ss; e.mask = mask; e.en = en;
        e.x = x; e.y = y; e.isel = isel; e.nib = nib; e.nxt = nxt;
        exp_q.push_back(e);
    endtask

    task automatic add_filler(input logic [7:0] a);
        logic [7:0] v;
        v = {1'b0, a[2:0], a[3:0]};
        rom[a] = v;
        push_exp(a, v, 4'd8, 3'b001, exp_dst_en(a[2:0]), 1'b0, 1'b0, 1'b0, 4'h0, a + 8'd1);
    endtask

    task automatic push_head(input int n);
        if (n > 0) push_exp(8'h00, 8'h05, 4'd8, 3'b001, 9'h001, 1'b0, 1'b0, 1'b0, 4'h0, 8'h01);
        if (n > 1) push_exp(8'h01, 8'h88, 4'd0, 3'b001, 9'h002, 1'b0, 1'b0, 1'b0, 4'h0, 8'h02);
        if (n > 2) push_exp(8'h02, 8'hB6, 4'd0, 3'b100, 9'h040, 1'b0, 1'b0, 1'b1, 4'h0, 8'h03);
    endtask

    task automatic clear_rom();
        for (int a = 0; a < 256; a++) begin
            rom[a]   = 8'h00;
            zflag[a] = 1'b0;
        end
    endtask

    task automatic load_main();
        clear_rom();
        rom[8'h00] = 8'h05;
        rom[8'h01] = 8'h88;
        rom[8'h02] = 8'hB6;
        rom[8'h03] = 8'h92;
        rom[8'h04] = 8'hDA;
        push_head(3);
        push_exp(8'h03, 8'h92, 4'd9, 3'b001, 9'h004, 1'b0, 1'b0, 1'b0, 4'h0, 8'h04);
        push_exp(8'h04, 8'hDA, 4'd0, 3'b010, 9'h010, 1'b1, 1'b1, 1'b0, 4'hA, 8'h05);
        for (int a = 5; a < 8'h23; a++) add_filler(8'(a));
        rom[8'h23] = 8'hF7; zflag[8'h23] = 1'b0;
        push_exp(8'h23, 8'hF7, 4'd0, 3'b000, 9'h000, 1'b0, 1'b0, 1'b0, 4'h0, 8'h27);
        rom[8'h27] = 8'hFA; zflag[8'h27] = 1'b1;
        push_exp(8'h27, 8'hFA, 4'd0, 3'b000, 9'h000, 1'b0, 1'b0, 1'b0, 4'h0, 8'h28);
        for (int a = 8'h28; a < 256; a++) add_filler(8'(a));
    endtask

    // Scoreboard: pops one expected record per EXEC cycle, then checks the
    // next fetch address once the FSM has left EXEC.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (mon_en) begin
            if (dbg_state == ST_EXEC) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_exec pc=%h ir=%h required=no exec", pc, ir);
                end else begin
                    e = exp_q.pop_front();
                    if (pc !== e.pc || ir !== e.ir) begin
                        n_err++;
                        $display("FAIL exec_pc_ir pc=%h ir=%h required pc=%h ir=%h", pc, ir, e.pc, e.ir);
                    end
                    n_cmp++;
                    if (reg_en !== e.en) begin
                        n_err++;
                        $display("FAIL reg_en pc=%h got=%h required=%h", e.pc, reg_en, e.en);
                    end
                    if (e.mask[0]) begin
                        n_cmp++;
                        if (source_sel !== e.ss) begin
                            n_err++;
                            $display("FAIL source_sel pc=%h got=%0d required=%0d", e.pc, source_sel, e.ss);
                        end
                    end
                    if (e.mask[1]) begin
                        n_cmp++;
                        if (x_sel !== e.x || y_sel !== e.y || nibble_ir !== e.nib) begin
                            n_err++;
                            $display("FAIL alu_sel pc=%h got x=%b y=%b nib=%h required x=%b y=%b nib=%h",
                                     e.pc, x_sel, y_sel, nibble_ir, e.x, e.y, e.nib);
                        end
                    end
                    if (e.mask[2]) begin
                        n_cmp++;
                        if (i_sel !== e.isel) begin
                            n_err++;
                            $display("FAIL i_sel pc=%h got=%b required=%b", e.pc, i_sel, e.isel);
                        end
                    end
                    pend_next = 1'b1;
                    exp_next  = e.nxt;
                end
            end else begin
                n_cmp++;
                if (reg_en !== 9'h000) begin
                    n_err++;
                    $display("FAIL idle_reg_en got=%h required=000", reg_en);
                end
                if (pend_next) begin
                    n_cmp++;
                    if (pm_addr !== exp_next) begin
                        n_err++;
                        $display("FAIL next_pm_addr got=%h required=%h", pm_addr, exp_next);
                    end
                    pend_next = 1'b0;
                end
            end
        end
    end

    task automatic drain(input string name, input int budget);
        bit done;
        done = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !pend_next) begin
                done = 1'b1;
                break;
            end
        end
        n_cmp++;
        if (!done) begin
            n_err++;
            $display("FAIL %s_drain left=%0d required=0", name, exp_q.size());
        end
    endtask

    task automatic test_reset();
        mon_en = 1'b0; reset_n = 1'b0; pend_next = 1'b0;
        exp_q.delete();
        load_main();
        repeat (2) @(negedge clk);
        n_cmp++;
        if (pc !== 8'h00 || ir !== 8'h00 || pm_addr !== 8'h00) begin
            n_err++;
            $display("FAIL reset_regs pc=%h ir=%h pm_addr=%h required 00", pc, ir, pm_addr);
        end
        n_cmp++;
        if (halted !== 1'b0 || reg_en !== 9'h000 || cu_sync_reset !== 1'b1) begin
            n_err++;
            $display("FAIL reset_ctrl halted=%b reg_en=%h sync=%b required 0/000/1", halted, reg_en, cu_sync_reset);
        end
        reset_n = 1'b1;
        mon_en  = 1'b1;
        #1;
        n_cmp++;
        if (cu_sync_reset !== 1'b1) begin
            n_err++;
            $display("FAIL sync_reset_rst got=%b required=1", cu_sync_reset);
        end
        @(negedge clk);
        n_cmp++;
        if (cu_sync_reset !== 1'b0 || pm_addr !== 8'h00) begin
            n_err++;
            $display("FAIL sync_reset_one_cycle sync=%b pm_addr=%h required 0/00", cu_sync_reset, pm_addr);
        end
`ifndef CU_SEQ_SINGLE_STEP_EN
        @(negedge clk);
        n_cmp++;
        if (reg_en !== 9'h000) begin
            n_err++;
            $display("FAIL latency_wait reg_en=%h required=000", reg_en);
        end
        @(negedge clk);
        n_cmp++;
        if (reg_en !== 9'h001 || source_sel !== 4'd8) begin
            n_err++;
            $display("FAIL latency_exec reg_en=%h ss=%0d required 001/8", reg_en, source_sel);
        end
        @(negedge clk);
        n_cmp++;
        if (reg_en !== 9'h000) begin
            n_err++;
            $display("FAIL exec_one_cycle reg_en=%h required=000", reg_en);
        end
`endif
    endtask

    task automatic test_program();
        drain("program", 3000);
    endtask

    task automatic test_reset_mid_wait();
        bit found;
        mon_en = 1'b0; reset_n = 1'b0; pend_next = 1'b0;
        exp_q.delete();
        @(negedge clk);
        push_head(2);
        reset_n = 1'b1;
        mon_en  = 1'b1;
        found   = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (dbg_state == ST_WAIT && pc == 8'h01) begin
                found = 1'b1;
                break;
            end
        end
        n_cmp++;
        if (!found) begin
            n_err++;
            $display("FAIL reach_wait pc=%h state=%0d required pc=01 in WAIT", pc, dbg_state);
        end
        mon_en = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        n_cmp++;
        if (reg_en !== 9'h000 || pc !== 8'h00 || cu_sync_reset !== 1'b1 || ir !== 8'h00) begin
            n_err++;
            $display("FAIL mid_wait_abort reg_en=%h pc=%h sync=%b ir=%h required 000/00/1/00",
                     reg_en, pc, cu_sync_reset, ir);
        end
        exp_q.delete();
        pend_next = 1'b0;
        push_head(3);
        @(negedge clk);
        reset_n = 1'b1;
        mon_en  = 1'b1;
        drain("restart", 100);
    endtask

    task automatic test_halt();
        bit seen;
        mon_en = 1'b0; reset_n = 1'b0; pend_next = 1'b0;
        exp_q.delete();
        clear_rom();
        for (int a = 0; a < 8'h14; a++) add_filler(8'(a));
        rom[8'h14] = 8'hE4;
        push_exp(8'h14, 8'hE4, 4'd0, 3'b000, 9'h000, 1'b0, 1'b0, 1'b0, 4'h0, 8'h14);
        @(negedge clk);
        reset_n = 1'b1;
        mon_en  = 1'b1;
        seen    = 1'b0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (halted === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        n_cmp++;
        if (!seen) begin
            n_err++;
            $display("FAIL halt_timeout halted=%b pc=%h required halted=1", halted, pc);
        end
        repeat (12) begin
            @(negedge clk);
            n_cmp++;
            if (pm_addr !== 8'h14 || halted !== 1'b1) begin
                n_err++;
                $display("FAIL halt_hold pm_addr=%h halted=%b required 14/1", pm_addr, halted);
            end
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL halt_queue left=%0d required=0", exp_q.size());
        end
    endtask

`ifdef CU_SEQ_SINGLE_STEP_EN
    task automatic test_single_step();
        mon_en = 1'b0; reset_n = 1'b0; pend_next = 1'b0;
        auto_step = 1'b0; step_man = 1'b0;
        load_main();
        exp_q.delete();
        @(negedge clk);
        reset_n = 1'b1;
        mon_en  = 1'b1;
        repeat (6) @(negedge clk);
        n_cmp++;
        if (step_idle !== 1'b1 || pc !== 8'h00) begin
            n_err++;
            $display("FAIL step_wait idle=%b pc=%h required 1/00", step_idle, pc);
        end
        for (int k = 0; k < 3; k++) begin
            exp_q.delete();
            push_head(3);
            for (int d = 0; d < k; d++) void'(exp_q.pop_front());
            while (exp_q.size() > 1) void'(exp_q.pop_back());
            step_man = 1'b1;
            repeat (2) @(negedge clk);
            step_man = 1'b0;
            repeat (8) @(negedge clk);
            n_cmp++;
            if (exp_q.size() != 0 || step_idle !== 1'b1 || pc !== 8'(k + 1)) begin
                n_err++;
                $display("FAIL single_step k=%0d left=%0d idle=%b pc=%h required 0/1/%h",
                         k, exp_q.size(), step_idle, pc, 8'(k + 1));
            end
        end
        auto_step = 1'b1;
    endtask
`endif

    initial begin
        #400000;
        $display("FAIL watchdog time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_program();
        test_reset_mid_wait();
        test_halt();
`ifdef CU_SEQ_SINGLE_STEP_EN
        test_single_step();
`endif
        mon_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
